clint_tick_sequencer: RTL and testbench



---
 rtl/clint_tick_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_clint_tick_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_tick_sequencer.sv
// clint_tick_sequencer: bus initiator toward the CLINT timer responder.
// On start it reads mtime atomically (hi / lo / hi, retrying on a carry into
// the high word), adds the programmed interval and writes the sum to
// mtimecmp using the glitch-free lo=all-ones / hi / lo order.
// Optional build macro TICK_AUTO_RELOAD_EN adds mtip/reload_en: an mtip rising
// edge in IDLE re-arms mtimecmp at target + interval without reading mtime.
module clint_tick_sequencer #(
   parameter logic [31:0] BASE         = 32'h0000_0000,
   parameter logic [31:0] MTIME_OFF    = 32'h0000_BFF8,
   parameter logic [31:0] MTIMECMP_OFF = 32'h0000_4000,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] interval,
   output logic        tmr_valid,
   output logic        tmr_instr,
   output logic [31:0] tmr_addr,
   output logic [31:0] tmr_wdata,
   output logic [3:0]  tmr_wstrb,
   input  logic [31:0] tmr_rdata,
   input  logic        tmr_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [63:0] target
`ifdef TICK_AUTO_RELOAD_EN
   ,
   input  logic        mtip,
   input  logic        reload_en
`endif
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [31:0] MT_LO  = BASE + MTIME_OFF;
   localparam logic [31:0] MT_HI  = BASE + MTIME_OFF + 32'd4;
   localparam logic [31:0] CMP_LO = BASE + MTIMECMP_OFF;
   localparam logic [31:0] CMP_HI = BASE + MTIMECMP_OFF + 32'd4;

   typedef enum logic [3:0] {
      IDLE, RD_HI1, RD_LO, RD_HI2, CALC, WR_LOMAX, WR_HI, WR_LO, FIN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [63:0]      interval_q;
   logic [31:0]      hi1;
   logic [31:0]      lo;
   logic [63:0]      tgt;
   logic             resp;
   logic             reload_edge;

   // A response only counts once the issue cycle is over.
   assign resp      = tmr_ready & ~tmr_valid;
   assign tmr_instr = 1'b0;

`ifdef TICK_AUTO_RELOAD_EN
   logic mtip_q;

   // Remember the previous mtip level for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!rst) mtip_q <= 1'b0;
      else      mtip_q <= mtip;
   end

   assign reload_edge = reload_en & mtip & ~mtip_q;
`else
   assign reload_edge = 1'b0;
`endif

   // Sequencer FSM: owns every bus output, status output and the wait counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         tmr_valid <= 1'b0;
         tmr_addr  <= '0;
         tmr_wdata <= '0;
         tmr_wstrb <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         target    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RD_HI1;
                  busy      <= 1'b1;
                  tmr_valid <= 1'b1;
                  tmr_addr  <= MT_HI;
                  tmr_wstrb <= 4'h0;
                  wait_cnt  <= '0;
               end else if (reload_edge) begin
                  state     <= WR_LOMAX;
                  busy      <= 1'b1;
                  tmr_valid <= 1'b1;
                  tmr_addr  <= CMP_LO;
                  tmr_wdata <= 32'hFFFF_FFFF;
                  tmr_wstrb <= 4'hF;
                  wait_cnt  <= '0;
               end
            end
            CALC: begin
               state     <= WR_LOMAX;
               tmr_valid <= 1'b1;
               tmr_addr  <= CMP_LO;
               tmr_wdata <= 32'hFFFF_FFFF;
               tmr_wstrb <= 4'hF;
               wait_cnt  <= '0;
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               // Shared access handling for every RD_* / WR_* state.
               if (tmr_valid) begin
                  tmr_valid <= 1'b0;
               end else if (tmr_ready) begin
                  wait_cnt <= '0;
                  case (state)
                     RD_HI1: begin
                        state     <= RD_LO;
                        tmr_valid <= 1'b1;
                        tmr_addr  <= MT_LO;
                     end
                     RD_LO: begin
                        state     <= RD_HI2;
                        tmr_valid <= 1'b1;
                        tmr_addr  <= MT_HI;
                     end
                     RD_HI2: begin
                        if (tmr_rdata != hi1) begin
                           state     <= RD_LO;
                           tmr_valid <= 1'b1;
                           tmr_addr  <= MT_LO;
                        end else begin
                           state <= CALC;
                        end
                     end
                     WR_LOMAX: begin
                        state     <= WR_HI;
                        tmr_valid <= 1'b1;
                        tmr_addr  <= CMP_HI;
                        tmr_wdata <= tgt[63:32];
                     end
                     WR_HI: begin
                        state     <= WR_LO;
                        tmr_valid <= 1'b1;
                        tmr_addr  <= CMP_LO;
                        tmr_wdata <= tgt[31:0];
                     end
                     default: begin
                        state  <= FIN;
                        target <= tgt;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                     end
                  endcase
               end else if (wait_cnt == CNT_LAST) begin
                  state <= FIN;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Datapath registers: latched interval, mtime words and the computed target.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) interval_q <= interval;
      if (resp && (state == RD_HI1 || state == RD_HI2)) hi1 <= tmr_rdata;
      if (resp && state == RD_LO) lo <= tmr_rdata;
      if (state == CALC) tgt <= {hi1, lo} + interval_q;
      else if (state == IDLE && !start && reload_edge) tgt <= target + interval_q;
   end

endmodule

// File: tb/tb_clint_tick_sequencer.sv
// Scoreboard bench for clint_tick_sequencer: stimulus queues the expected bus
// accesses and completions; a negedge monitor pops and compares them.
// A small responder returns ready one cycle after each request.
module tb_clint_tick_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] interval;
   logic        tmr_valid;
   logic        tmr_instr;
   logic [31:0] tmr_addr;
   logic [31:0] tmr_wdata;
   logic [3:0]  tmr_wstrb;
   logic [31:0] tmr_rdata;
   logic        tmr_ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] target;
`ifdef TICK_AUTO_RELOAD_EN
   logic        mtip;
   logic        reload_en;
`endif

   clint_tick_sequencer #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .interval(interval),
      .tmr_valid(tmr_valid), .tmr_instr(tmr_instr), .tmr_addr(tmr_addr),
      .tmr_wdata(tmr_wdata), .tmr_wstrb(tmr_wstrb), .tmr_rdata(tmr_rdata),
      .tmr_ready(tmr_ready), .busy(busy), .done(done), .err(err),
      .target(target)
`ifdef TICK_AUTO_RELOAD_EN
      , .mtip(mtip), .reload_en(reload_en)
`endif
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_t;

   typedef struct packed {
      logic        err;
      logic [63:0] tgt;
      logic [31:0] lat;
   } done_t;

   bus_t        exp_bus[$];
   done_t       exp_done[$];
   logic [31:0] rd_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   logic        silent_en = 1'b0;
   logic [31:0] silent_addr = '0;
   logic [3:0]  silent_wstrb = '0;
   int          inject_req = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic exp_rd(input logic [31:0] a);
      exp_bus.push_back('{addr: a, wdata: 32'h0, wstrb: 4'h0});
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      exp_bus.push_back('{addr: a, wdata: d, wstrb: 4'hF});
   endtask

   task automatic exp_fin(input logic e, input logic [63:0] t, input int l);
      exp_done.push_back('{err: e, tgt: t, lat: 32'(l)});
   endtask

   task automatic pulse_start(input logic [63:0] iv);
      @(posedge clk); #1;
      interval  = iv;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_bus.size() != 0 || exp_done.size() != 0 || busy) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_drain_cycles_over_budget"}, 64'(n >= 100), 64'd0);
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_valid"}, 64'(tmr_valid), 64'd0);
      chk({name, "_busy"},  64'(busy),      64'd0);
      chk({name, "_done"},  64'(done),      64'd0);
      chk({name, "_err"},   64'(err),       64'd0);
      chk({name, "_target"}, target,        64'd0);
      chk({name, "_addr"},  64'(tmr_addr),  64'd0);
      chk({name, "_wdata"}, 64'(tmr_wdata), 64'd0);
      chk({name, "_wstrb"}, 64'(tmr_wstrb), 64'd0);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Responder: ready (with read data) one cycle after each request.
   initial begin
      logic        pending;
      logic [31:0] next_rdata;
      int          inject_ack;
      pending    = 1'b0;
      next_rdata = '0;
      inject_ack = 0;
      tmr_ready  = 1'b0;
      tmr_rdata  = '0;
      forever begin
         @(posedge clk); #1;
         tmr_ready = 1'b0;
         if (pending) begin
            tmr_ready = 1'b1;
            tmr_rdata = next_rdata;
            pending   = 1'b0;
         end
         if (inject_req != inject_ack) begin
            inject_ack = inject_req;
            tmr_ready  = 1'b1;
            tmr_rdata  = 32'h1234_5678;
         end
         if (tmr_valid && rst) begin
            if (!(silent_en && tmr_addr == silent_addr && tmr_wstrb == silent_wstrb)) begin
               pending = 1'b1;
               if (tmr_wstrb == 4'h0 && rd_q.size() != 0) next_rdata = rd_q.pop_front();
               else next_rdata = 32'h0;
            end
         end
      end
   end

   // Monitor: compares every presented access and completion with the scoreboard.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (tmr_valid) begin
            if (exp_bus.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access actual=addr %0h wstrb %0h required=no access",
                        tmr_addr, tmr_wstrb);
            end else begin
               bus_t e;
               e = exp_bus.pop_front();
               chk("bus_addr", 64'(tmr_addr), 64'(e.addr));
               chk("bus_wstrb", 64'(tmr_wstrb), 64'(e.wstrb));
               if (e.wstrb != 4'h0) chk("bus_wdata", 64'(tmr_wdata), 64'(e.wdata));
               chk("bus_instr", 64'(tmr_instr), 64'd0);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=done err %0d required=no done", err);
            end else begin
               done_t d;
               d = exp_done.pop_front();
               chk("done_err", 64'(err), 64'(d.err));
               chk("done_target", target, d.tgt);
               chk("done_busy", 64'(busy), 64'd0);
               chk("done_latency", 64'(cyc - start_cyc), 64'(d.lat));
            end
         end else begin
            chk("err_without_done", 64'(err), 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      interval = '0;
`ifdef TICK_AUTO_RELOAD_EN
      mtip      = 1'b0;
      reload_en = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b1;

      // Basic: mtime 0x1_FFFF_FFF0 + 0x20, start pulse in the FIN cycle is dropped.
      rd_q = '{32'h1, 32'hFFFF_FFF0, 32'h1};
      exp_rd(32'hBFFC); exp_rd(32'hBFF8); exp_rd(32'hBFFC);
      exp_wr(32'h4000, 32'hFFFF_FFFF); exp_wr(32'h4004, 32'h2); exp_wr(32'h4000, 32'h10);
      exp_fin(1'b0, 64'h0000_0002_0000_0010, 14);
      pulse_start(64'h20);
      repeat (13) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain("basic");
      repeat (20) @(posedge clk);
      #1;
      chk("fin_start_dropped_busy", 64'(busy), 64'd0);

      // Rollover: high word changes between reads, one retry.
      rd_q = '{32'h1, 32'hFFFF_FFFE, 32'h2, 32'h3, 32'h2};
      exp_rd(32'hBFFC); exp_rd(32'hBFF8); exp_rd(32'hBFFC); exp_rd(32'hBFF8); exp_rd(32'hBFFC);
      exp_wr(32'h4000, 32'hFFFF_FFFF); exp_wr(32'h4004, 32'h2); exp_wr(32'h4000, 32'h8);
      exp_fin(1'b0, 64'h0000_0002_0000_0008, 18);
      pulse_start(64'h5);
      wait_drain("rollover");

      // Timeout: responder silent on the low mtime read; issue +3, 16 wait cycles.
      silent_en    = 1'b1;
      silent_addr  = 32'hBFF8;
      silent_wstrb = 4'h0;
      rd_q = '{32'h5};
      exp_rd(32'hBFFC); exp_rd(32'hBFF8);
      exp_fin(1'b1, 64'h0000_0002_0000_0008, 20);
      pulse_start(64'h40);
      wait_drain("timeout");
      silent_en = 1'b0;
      chk("timeout_target_kept", target, 64'h0000_0002_0000_0008);

      // Wrap: all-ones mtime + 2; a second start while busy must not run.
      rd_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      exp_rd(32'hBFFC); exp_rd(32'hBFF8); exp_rd(32'hBFFC);
      exp_wr(32'h4000, 32'hFFFF_FFFF); exp_wr(32'h4004, 32'h0); exp_wr(32'h4000, 32'h1);
      exp_fin(1'b0, 64'h1, 14);
      pulse_start(64'h2);
      repeat (3) @(posedge clk);
      #1;
      interval = 64'h77;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain("wrap");
      repeat (20) @(posedge clk);
      #1;
      chk("busy_start_dropped", 64'(busy), 64'd0);
      chk("wrap_target_final", target, 64'h1);

      // Reset during the WR_HI wait, then a late ready that must be ignored.
      silent_en    = 1'b1;
      silent_addr  = 32'h4004;
      silent_wstrb = 4'hF;
      rd_q = '{32'h0, 32'h0, 32'h0};
      exp_rd(32'hBFFC); exp_rd(32'hBFF8); exp_rd(32'hBFFC);
      exp_wr(32'h4000, 32'hFFFF_FFFF); exp_wr(32'h4004, 32'h0);
      pulse_start(64'h10);
      repeat (11) @(posedge clk);
      #1;
      chk("midreset_busy_before", 64'(busy), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_idle_outputs("midreset");
      rst = 1'b1;
      inject_req++;
      repeat (6) @(posedge clk);
      #1;
      chk("late_ready_busy", 64'(busy), 64'd0);
      chk("late_ready_target", target, 64'd0);
      silent_en = 1'b0;
      chk("midreset_queue_left", 64'(exp_bus.size()), 64'd0);

`ifdef TICK_AUTO_RELOAD_EN
      // Auto reload: target 0x100, then each mtip edge adds 0x100 with writes only.
      rd_q = '{32'h0, 32'h0, 32'h0};
      exp_rd(32'hBFFC); exp_rd(32'hBFF8); exp_rd(32'hBFFC);
      exp_wr(32'h4000, 32'hFFFF_FFFF); exp_wr(32'h4004, 32'h0); exp_wr(32'h4000, 32'h100);
      exp_fin(1'b0, 64'h100, 14);
      pulse_start(64'h100);
      wait_drain("reload_setup");
      reload_en = 1'b1;
      for (int k = 2; k <= 3; k++) begin
         exp_wr(32'h4000, 32'hFFFF_FFFF); exp_wr(32'h4004, 32'h0);
         exp_wr(32'h4000, 32'(k * 256));
         exp_fin(1'b0, 64'(k * 256), 7);
         @(posedge clk); #1;
         mtip      = 1'b1;
         start_cyc = cyc;
         wait_drain("reload_edge");
         mtip = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end
      chk("reload_target_final", target, 64'h300);
`endif

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
